serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell processes a WIDTH-bit add LSB-first,
// one bit per clock, with the carry recirculated through a flop.
// Optional build macro SERIAL_ADD_SUB_EN adds a `sub` port for a - b (two's complement).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, r_q;
    logic             c_q;
    logic [CntW-1:0]  cnt_q;

    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] sb_load;
    logic             c_load;

    // Full adder built from two half adders
    logic ha0_s, ha0_c, ha1_c, fa_sum, fa_carry;

    assign ha0_s    = sa_q[0] ^ sb_q[0];
    assign ha0_c    = sa_q[0] & sb_q[0];
    assign fa_sum   = ha0_s ^ c_q;
    assign ha1_c    = ha0_s & c_q;
    assign fa_carry = ha0_c | ha1_c;

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // Operand B / initial carry selection; subtraction is a + ~b + 1
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        sb_load = sub ? ~b : b;
        c_load  = sub ? 1'b1 : cin;
`else
        sb_load = b;
        c_load  = cin;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and status outputs; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: load on accept, shift one bit pair per RUN cycle; result held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q  <= '0;
            sb_q  <= '0;
            r_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            sa_q  <= a;
            sb_q  <= sb_load;
            c_q   <= c_load;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            r_q   <= {fa_sum, r_q[WIDTH-1:1]};
            c_q   <= fa_carry;
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign sum  = r_q;
    assign cout = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): expected {cout,sum} pushed at issue,
// popped and compared by a monitor whenever done is seen.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: pop expected result on every done pulse
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", 32'({cout, sum}), 32'(e));
            end
        end
    end

    // Issue one operation and check busy length, latency, pulse width and hold
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic sb, input logic [W:0] expv);
        int lat;
        int busy_n;
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd9);
        chk("busy_cycles", 32'(busy_n), 32'd8);
        @(negedge clk);
        chk("done_one_cycle", 32'({done, busy}), 32'd0);
        chk("sum_held", 32'({cout, sum}), 32'(expv));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL %s: got no done expected done within 40 cycles", name);
        end
    endtask

    initial begin
        int d0;
        int c1;
        int c2;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, cout, sum}), 32'd0);
        rst = 1'b0;

        // Directed add vectors
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100);
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B);

        // start during RUN is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h046);
        @(negedge clk);
        start = 1'b0;
        a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("ignored_start_one_done", 32'(done_cnt - d0), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h003);
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        exp_q.push_back(9'h030);
        wait_done("b2b_first");
        c1 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second");
        c2 = cyc;
        chk("b2b_spacing", 32'(c2 - c1), 32'd9);
        chk("b2b_busy_in_run", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset mid-RUN
        a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h0FF);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_run_outputs", 32'({busy, done, cout, sum}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);

        // start and rst together: rst wins
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        chk("rst_beats_start", 32'({busy, done}), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_rst_start", 32'(busy), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF);
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B);
`endif

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
